data_mem_responder: RTL
=======================

# data_mem_responder

Multi-cycle data-memory responder serving the pipeline's memory stage over a valid/ready request/response handshake. It replaces the single-cycle data memory at the far end of the MEM-stage access path. It accepts one word load or store at a time, waits a parameterised access latency, then returns read data plus an error flag. Its `busy` output feeds the hazard unit so the pipeline stalls while an access is outstanding.

## Interface
- `DEPTH`, 1024: number of 32-bit words held; legal word indices 0..DEPTH-1.
- `LATENCY`, 2: access latency in cycles, legal range 1..15.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `req_valid`  in  1  MEM stage presents a request.
- `req_ready`  out  1  responder can accept a request; high only in IDLE.
- `req_we`  in  1  1 = store, 0 = load.
- `req_addr`  in  32  byte address; word index = `req_addr[31:2]`.
- `req_wdata`  in  32  store data.
- `rsp_valid`  out  1  response available; high only in RESP.
- `rsp_ready`  in  1  MEM stage consumes the response.
- `rsp_rdata`  out  32  load data; 0 for stores and for errored accesses.
- `rsp_err`  out  1  misaligned or out-of-range access.
- `busy`  out  1  equals `~req_ready`; the hazard unit stalls F/D/E/M while this is high.

## Operation
- Three-state FSM: IDLE, WAIT, RESP. There is also a 4-bit down-counter `cnt`.
- **IDLE**
  - `req_ready`=1.
  - A handshake (`req_valid & req_ready`) latches `req_we`, `req_addr` and `req_wdata`, loads `cnt` with LATENCY-1, and moves to WAIT.
  - With no `req_valid`, the FSM stays in IDLE.
- **WAIT**
  - If `cnt`≠0, decrement `cnt`.
  - If `cnt`=0, perform the access on the latched fields and move to RESP.
  - Error condition: `addr[1:0]`≠0 or word index ≥ DEPTH. The result is `rsp_err`=1, `rsp_rdata`=0, and the memory is unchanged.
  - Load without error: `rsp_rdata` = mem[index], `rsp_err`=0.
  - Store without error: mem[index] = wdata, `rsp_rdata`=0, `rsp_err`=0.
- **RESP**
  - `rsp_valid`=1. `rsp_rdata` and `rsp_err` are held stable until consumed.
  - On `rsp_ready`=1, move to IDLE and clear `rsp_rdata` and `rsp_err` to 0.
- Request inputs are sampled only at the handshake. Changes after acceptance are ignored.
- Only one transaction is ever outstanding; there is no queueing.
- Memory contents are not cleared by reset. A store is committed only at the WAIT→RESP edge.

## Timing
- Reset values: state IDLE, `cnt`=0, `req_ready`=1, `busy`=0, `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0.
- Latency: if the handshake occurs in cycle 0, WAIT occupies cycles 1..LATENCY and `rsp_valid` first rises in cycle LATENCY+1.
  - LATENCY=1 gives a response in cycle 2.
  - LATENCY=15 gives a response in cycle 16.
- Minimum transaction period is LATENCY+2 cycles (handshake, WAIT, one RESP cycle, then IDLE), assuming `rsp_ready` is held high.
- A `rsp_ready` stall extends RESP indefinitely with outputs frozen.
- Response consumed and new request in the same cycle: the request is not accepted because `req_ready`=0 in RESP. The earliest acceptance is the following IDLE cycle.
- `rsp_ready` asserted outside RESP has no effect.
- Reset asserted mid-operation: immediate return to IDLE with all outputs at reset values.
  - If reset hits during WAIT, the pending store is dropped.
  - If reset hits during RESP, the store has already been committed and persists.
- `busy` is combinational from the state, with no extra register stage.

## Test plan
- Reset then idle: `rst` low then high, no requests → `req_ready`=1, `busy`=0, `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0 in every cycle.
- Store then load, LATENCY=2:
  - Store addr 0x10, data 0xDEADBEEF, accepted in cycle 0 → `rsp_valid` in cycle 3 with `rsp_rdata`=0 and `rsp_err`=0.
  - Load addr 0x10 → `rsp_rdata`=0xDEADBEEF.
- Errors:
  - Load addr 0x13 → `rsp_err`=1, `rsp_rdata`=0.
  - Store to addr 4·DEPTH (0x1000), data 0x1 → `rsp_err`=1, and a later load of addr 0x0 returns its prior value.
- Backpressure:
  - Hold `rsp_ready`=0 for 5 cycles on a load of 0x10 → `rsp_valid` and `rsp_rdata`=0xDEADBEEF stay stable throughout, and `req_ready`=0.
  - Consume while `req_valid` is high → the new request is accepted exactly one cycle later.
- Reset mid-WAIT: store 0x20 = 0x12345678 with LATENCY=4, assert `rst` in cycle 2 → outputs at reset values, and a later load of 0x20 returns the old contents (0 after a prior store of 0).
- Latency sweep: LATENCY=1 and LATENCY=15 → `rsp_valid` first rises in cycle 2 and cycle 16 respectively; `busy` is high from cycle 1 until the consume cycle.

Source files
------------

// File: rtl/data_mem_responder.sv
// data_mem_responder
// Multi-cycle data memory behind the MEM stage. It accepts one word load or
// store at a time over a valid/ready request channel. It waits LATENCY
// cycles, then returns read data and an error flag over a valid/ready
// response channel. `busy` tells the hazard unit to stall the pipeline while
// an access is outstanding.
module data_mem_responder #(
  parameter int DEPTH   = 1024,  // number of 32-bit words
  parameter int LATENCY = 2      // access latency in cycles, 1..15
) (
  input  logic        clk,
  input  logic        rst,        // asynchronous, active-low
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } stateType;

  stateType   state, nextState;
  logic [3:0] cnt, nextCnt;

  // Request fields captured at the handshake. Later changes on the request
  // inputs cannot disturb the access in flight.
  logic        latWe;
  logic [31:0] latAddr;
  logic [31:0] latWdata;

  logic [31:0] mem [DEPTH];

  logic             acceptReq;
  logic             accessNow;
  logic             accessErr;
  logic [IDX_W-1:0] wordIdx;

  // Handshake and access strobes, plus the error check on the latched address.
  assign acceptReq = (state == IDLE) && req_valid;
  assign accessNow = (state == WAIT) && (cnt == 4'd0);
  assign accessErr = (latAddr[1:0] != 2'b00) || (latAddr[31:2] >= 30'(DEPTH));
  assign wordIdx   = latAddr[IDX_W+1:2];

  // Handshake and status outputs decoded straight from the state, with no extra register stage.
  assign req_ready = (state == IDLE);
  assign busy      = ~req_ready;
  assign rsp_valid = (state == RESP);

  // Registers for the state and the latency down-counter.
  // NOTE: use non-blocking assignments for every flop. All registers then
  // sample the values from before the edge, whatever order the blocks run in.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= nextState;
      cnt   <= nextCnt;
    end
  end

  // Next-state and next-count logic.
  // NOTE: every output of this block gets a default first. A path that does
  // not assign a signal would otherwise infer a latch.
  always_comb begin
    nextState = state;
    nextCnt   = cnt;
    unique case (state)
      IDLE: begin
        if (req_valid) begin
          nextState = WAIT;
          nextCnt   = CNT_INIT;
        end
      end
      WAIT: begin
        if (cnt == 4'd0) nextState = RESP;
        else             nextCnt   = cnt - 4'd1;
      end
      RESP: begin
        if (rsp_ready) nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  // Capture the request fields on the handshake only.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      latWe    <= 1'b0;
      latAddr  <= 32'd0;
      latWdata <= 32'd0;
    end else if (acceptReq) begin
      latWe    <= req_we;
      latAddr  <= req_addr;
      latWdata <= req_wdata;
    end
  end

  // Response registers. They are loaded when the access completes, held
  // through RESP, and cleared when the response is consumed.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
    end else if (accessNow) begin
      rsp_err   <= accessErr;
      rsp_rdata <= (!accessErr && !latWe) ? mem[wordIdx] : 32'd0;
    end else if ((state == RESP) && rsp_ready) begin
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
    end
  end

  // Store commit at the WAIT->RESP edge. Errored stores leave memory untouched.
  // NOTE: the memory array has no reset. Its contents survive rst, and a RAM
  // macro cannot be cleared in one cycle anyway.
  always_ff @(posedge clk) begin
    if (accessNow && latWe && !accessErr) begin
      mem[wordIdx] <= latWdata;
    end
  end

endmodule
